branch_resolver: RTL and testbench

Execute-stage branch resolution unit with a 2-bit dynamic predictor for conditional branches. It consumes the same `PCsrc` codes from `def.sv` that drive PC selection and the ALU condition flag `EQ`, and holds a branch history table (BHT) that fetch reads. It also produces a registered one-cycle redirect/flush to the fetch PC mux and keeps branch and mispredict statistics.

---
 rtl/branch_resolver.sv | 148 ++++++++++++++
 tb/tb_branch_resolver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - execute-stage branch resolution with 2-bit dynamic predictor
//
// Resolves the PC source of the instruction in EX, issues a registered
// one-cycle redirect to the fetch PC mux, trains a table of 2-bit counters
// (read combinationally by fetch) and keeps saturating branch statistics.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall              EX stage held; EX inputs are not consumed
//   if_pc              fetch PC used to index the prediction table
//   if_pred_taken      MSB of the counter at if_pc's index (combinational)
//   ex_valid           EX holds a real instruction
//   ex_PCsrc           PC source code of the EX instruction
//   ex_EQ              ALU condition result
//   ex_pc              PC of the EX instruction
//   ex_pred_taken      prediction carried down the pipe with the instruction
//   ex_branch_target   pc + imm
//   ex_jalr_target     (rs1 + imm) & ~1
//   redirect           registered one-cycle flush/redirect pulse
//   redirect_pc        registered target, valid while redirect is high
//   branch_count       resolved conditional branches, saturating
//   mispredict_count   conditional mispredicts, saturating

module branch_resolver #(
    parameter int WIDTH       = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [WIDTH-1:0]     if_pc,
    output logic                 if_pred_taken,
    input  logic                 ex_valid,
    input  logic [2:0]           ex_PCsrc,
    input  logic                 ex_EQ,
    input  logic [WIDTH-1:0]     ex_pc,
    input  logic                 ex_pred_taken,
    input  logic [WIDTH-1:0]     ex_branch_target,
    input  logic [WIDTH-1:0]     ex_jalr_target,
    output logic                 redirect,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    // PC source encodings shared with the PC select mux
    localparam logic [2:0] PC_NEXT            = 3'd0;
    localparam logic [2:0] PC_ALWAYS_BRANCH   = 3'd1;
    localparam logic [2:0] PC_JALR            = 3'd2;
    localparam logic [2:0] PC_COND_BRANCH     = 3'd3;
    localparam logic [2:0] PC_INV_COND_BRANCH = 3'd4;

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;

    logic             res;
    logic             is_cond;
    logic             taken;
    logic             mispredict;
    logic             next_redirect;
    logic [WIDTH-1:0] next_pc;

    // Only the word-aligned index bits of the fetch PC select a counter
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[WIDTH-1:IDX_W+2], if_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Old counter value is returned even when the same entry is written this cycle
    assign if_pred_taken = bht[if_idx][1];

    // The instruction sitting in EX during a redirect cycle is wrong-path
    assign res = ex_valid & ~stall & ~redirect;

    always_comb begin
        is_cond       = 1'b0;
        taken         = 1'b0;
        next_redirect = 1'b0;
        next_pc       = '0;
        case (ex_PCsrc)
            PC_ALWAYS_BRANCH: begin
                next_redirect = res;
                next_pc       = ex_branch_target;
            end
            PC_JALR: begin
                next_redirect = res;
                next_pc       = ex_jalr_target;
            end
            PC_COND_BRANCH: begin
                is_cond = 1'b1;
                taken   = ex_EQ;
            end
            PC_INV_COND_BRANCH: begin
                is_cond = 1'b1;
                taken   = ~ex_EQ;
            end
            default: begin
                is_cond = 1'b0;
            end
        endcase
        mispredict = is_cond & (taken != ex_pred_taken);
        if (res && mispredict) begin
            next_redirect = 1'b1;
            next_pc       = taken ? ex_branch_target : ex_pc + WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'd1;
            end
        end else begin
            // next_redirect is already gated by res, so a stalled cycle drops the pulse
            redirect <= next_redirect;
            if (next_redirect) begin
                redirect_pc <= next_pc;
            end
            if (res && is_cond) begin
                if (branch_count != {CNT_WIDTH{1'b1}}) begin
                    branch_count <= branch_count + 1'b1;
                end
                if (mispredict && (mispredict_count != {CNT_WIDTH{1'b1}})) begin
                    mispredict_count <= mispredict_count + 1'b1;
                end
                if (taken) begin
                    if (bht[ex_idx] != 2'd3) begin
                        bht[ex_idx] <= bht[ex_idx] + 2'd1;
                    end
                end else begin
                    if (bht[ex_idx] != 2'd0) begin
                        bht[ex_idx] <= bht[ex_idx] - 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver

module tb_branch_resolver;

    localparam logic [2:0] PC_NEXT            = 3'd0;
    localparam logic [2:0] PC_ALWAYS_BRANCH   = 3'd1;
    localparam logic [2:0] PC_JALR            = 3'd2;
    localparam logic [2:0] PC_COND_BRANCH     = 3'd3;
    localparam logic [2:0] PC_INV_COND_BRANCH = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_pcsrc = PC_NEXT;
    logic        ex_eq = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_pred = 1'b0;
    logic [31:0] ex_bt = '0;
    logic [31:0] ex_jt = '0;

    logic        m_pred;
    logic        m_redirect;
    logic [31:0] m_redirect_pc;
    logic [31:0] m_branch_count;
    logic [31:0] m_mispredict_count;

    logic        s_pred;
    logic        s_redirect;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_branch_count;
    logic [2:0]  s_mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_pred_taken(m_pred),
        .ex_valid(ex_valid), .ex_PCsrc(ex_pcsrc), .ex_EQ(ex_eq), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred), .ex_branch_target(ex_bt), .ex_jalr_target(ex_jt),
        .redirect(m_redirect), .redirect_pc(m_redirect_pc),
        .branch_count(m_branch_count), .mispredict_count(m_mispredict_count)
    );

    branch_resolver #(.CNT_WIDTH(3)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_pred_taken(s_pred),
        .ex_valid(ex_valid), .ex_PCsrc(ex_pcsrc), .ex_EQ(ex_eq), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred), .ex_branch_target(ex_bt), .ex_jalr_target(ex_jt),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        ex_pcsrc = PC_NEXT;
        stall    = 1'b0;
    endtask

    task automatic drive(input logic [2:0] src, input logic eq, input logic pred,
                         input logic [31:0] pc, input logic [31:0] bt, input logic [31:0] jt);
        ex_valid = 1'b1;
        ex_pcsrc = src;
        ex_eq    = eq;
        ex_pred  = pred;
        ex_pc    = pc;
        ex_bt    = bt;
        ex_jt    = jt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic peek_pred(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, m_pred, exp);
    endtask

    initial begin
        // Reset state and full table sweep
        do_reset();
        check("rst_redirect", m_redirect, 0);
        check("rst_redirect_pc", m_redirect_pc, 0);
        check("rst_branch_count", m_branch_count, 0);
        check("rst_mispredict_count", m_mispredict_count, 0);
        for (int i = 0; i < 16; i++) begin
            peek_pred($sformatf("rst_pred_idx%0d", i), 32'(i * 4), 1'b0);
        end

        // Mispredicted taken branch, trained twice to strong-T
        drive(PC_COND_BRANCH, 1'b1, 1'b0, 32'h100, 32'h140, 32'h0);
        peek_pred("same_cycle_old_value", 32'h100, 1'b0);
        tick();
        idle();
        check("mp_redirect", m_redirect, 1);
        check("mp_redirect_pc", m_redirect_pc, 32'h140);
        check("mp_branch_count", m_branch_count, 1);
        check("mp_mispredict_count", m_mispredict_count, 1);
        peek_pred("mp_pred_after_1", 32'h100, 1'b1);
        tick();
        check("mp_redirect_one_cycle", m_redirect, 0);
        drive(PC_COND_BRANCH, 1'b1, 1'b0, 32'h100, 32'h140, 32'h0);
        tick();
        idle();
        check("mp2_redirect", m_redirect, 1);
        check("mp2_mispredict_count", m_mispredict_count, 2);
        tick();
        // Not-taken on a strong-T entry: 3 -> 2 keeps predicting taken
        drive(PC_COND_BRANCH, 1'b0, 1'b1, 32'h100, 32'h140, 32'h0);
        tick();
        idle();
        check("nt_redirect", m_redirect, 1);
        check("nt_redirect_pc_fallthrough", m_redirect_pc, 32'h104);
        check("nt_branch_count", m_branch_count, 3);
        peek_pred("strong_t_decays_to_weak_t", 32'h100, 1'b1);
        tick();

        // Correct not-taken prediction via inverted condition
        do_reset();
        drive(PC_INV_COND_BRANCH, 1'b1, 1'b0, 32'h200, 32'h280, 32'h0);
        tick();
        check("cnt_no_redirect", m_redirect, 0);
        check("cnt_branch_count", m_branch_count, 1);
        check("cnt_mispredict_count", m_mispredict_count, 0);
        tick();
        check("cnt_no_redirect_2", m_redirect, 0);
        check("cnt_branch_count_2", m_branch_count, 2);
        // A taken branch now lifts 0 -> 1, still predicting not taken
        drive(PC_COND_BRANCH, 1'b1, 1'b0, 32'h200, 32'h280, 32'h0);
        tick();
        idle();
        check("cnt_taken_redirect_pc", m_redirect_pc, 32'h280);
        peek_pred("cnt_counter_saturated_low", 32'h200, 1'b0);
        tick();

        // Fall-through address wraps modulo 2^32
        drive(PC_COND_BRANCH, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0);
        tick();
        idle();
        check("wrap_redirect", m_redirect, 1);
        check("wrap_redirect_pc", m_redirect_pc, 32'h0);
        tick();

        // JALR followed by a squashed mispredicting branch
        do_reset();
        drive(PC_JALR, 1'b0, 1'b0, 32'h300, 32'h0, 32'h3FE);
        tick();
        check("jalr_redirect", m_redirect, 1);
        check("jalr_redirect_pc", m_redirect_pc, 32'h3FE);
        check("jalr_no_count", m_branch_count, 0);
        drive(PC_COND_BRANCH, 1'b1, 1'b0, 32'h100, 32'h140, 32'h0);
        tick();
        idle();
        check("squash_no_redirect", m_redirect, 0);
        check("squash_branch_count", m_branch_count, 0);
        check("squash_mispredict_count", m_mispredict_count, 0);
        peek_pred("squash_bht_unchanged", 32'h100, 1'b0);

        // Always-branch and an unused code
        drive(PC_ALWAYS_BRANCH, 1'b0, 1'b0, 32'h500, 32'h5A0, 32'h0);
        tick();
        idle();
        check("always_redirect", m_redirect, 1);
        check("always_redirect_pc", m_redirect_pc, 32'h5A0);
        check("always_no_count", m_branch_count, 0);
        tick();
        drive(3'd6, 1'b1, 1'b0, 32'h100, 32'h140, 32'h0);
        tick();
        idle();
        check("badcode_no_redirect", m_redirect, 0);
        check("badcode_no_count", m_branch_count, 0);

        // Stall holds a mispredicting branch
        do_reset();
        drive(PC_COND_BRANCH, 1'b1, 1'b0, 32'h100, 32'h140, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_no_redirect_%0d", i), m_redirect, 0);
            check($sformatf("stall_no_count_%0d", i), m_branch_count, 0);
        end
        stall = 1'b0;
        tick();
        check("stall_release_redirect", m_redirect, 1);
        check("stall_release_pc", m_redirect_pc, 32'h140);
        check("stall_release_count", m_branch_count, 1);
        stall = 1'b1;
        tick();
        check("redirect_drops_under_stall", m_redirect, 0);
        check("stall_count_held", m_branch_count, 1);
        idle();
        tick();

        // Reset wins over a redirect generated at the same edge
        drive(PC_COND_BRANCH, 1'b1, 1'b0, 32'h100, 32'h140, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("rst_prio_redirect", m_redirect, 0);
        check("rst_prio_redirect_pc", m_redirect_pc, 0);
        check("rst_prio_branch_count", m_branch_count, 0);
        peek_pred("rst_prio_bht", 32'h100, 1'b0);

        // Counter saturation on the 3-bit instance
        for (int i = 0; i < 9; i++) begin
            drive(PC_COND_BRANCH, 1'b0, 1'b1, 32'h400, 32'h440, 32'h0);
            tick();
            idle();
            tick();
        end
        check("sat_main_mispredict", m_mispredict_count, 9);
        check("sat_main_branch", m_branch_count, 9);
        check("sat_small_mispredict", s_mispredict_count, 7);
        check("sat_small_branch", s_branch_count, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
